// File: rtl/reg_spill_fill.sv
// reg_spill_fill: saves the 8-entry register bank onto a memory stack and restores it; define REG_SPILL_CLEAR_EN to zero each register after it is saved
module reg_spill_fill #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int ID_W   = 3,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              saveReq,
    input  logic              restoreReq,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] sp,
    output logic [ID_W-1:0]   rId,
    output logic              ldR,
    output logic [WIDTH-1:0]  rIn,
    input  logic [WIDTH-1:0]  rOut,
    output logic [ADDR_W-1:0] memAddr,
    output logic [WIDTH-1:0]  memWData,
    output logic              memWe,
    output logic              memRe,
    input  logic [WIDTH-1:0]  memRData,
    input  logic              memAck
);
    localparam logic [ID_W-1:0]   LAST   = ID_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] SP_MAX = ADDR_W'((1 << ADDR_W) - NREGS);
    localparam logic [ADDR_W-1:0] NR     = ADDR_W'(NREGS);

    typedef enum logic [3:0] {
        IDLE, S_RD, S_WR, R_RD, R_SET, R_LD, R_HLD, FIN
`ifdef REG_SPILL_CLEAR_EN
        , C_SET, C_LD, C_HLD
`endif
    } state_t;

    state_t          state;
    logic [ID_W-1:0] idx;

    // Single FSM; every output is a register loaded on entry to the state that drives it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            sp       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rId      <= '0;
            ldR      <= 1'b0;
            rIn      <= '0;
            memAddr  <= '0;
            memWData <= '0;
            memWe    <= 1'b0;
            memRe    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            ldR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (saveReq) begin
                        if (sp <= SP_MAX) begin
                            state <= S_RD;
                            busy  <= 1'b1;
                            idx   <= '0;
                            rId   <= '0;
                        end else err <= 1'b1;
                    end else if (restoreReq) begin
                        if (sp >= NR) begin
                            state   <= R_RD;
                            busy    <= 1'b1;
                            idx     <= LAST;
                            memRe   <= 1'b1;
                            memAddr <= sp - 1'b1;
                        end else err <= 1'b1;
                    end
                end
                S_RD: begin
                    memWData <= rOut;
                    memWe    <= 1'b1;
                    memAddr  <= sp;
                    state    <= S_WR;
                end
                S_WR: if (memAck) begin
                    memWe <= 1'b0;
                    sp    <= sp + 1'b1;
`ifdef REG_SPILL_CLEAR_EN
                    rIn   <= '0;
                    state <= C_SET;
                end
                C_SET: begin
                    ldR   <= 1'b1;
                    state <= C_LD;
                end
                C_LD: state <= C_HLD;
                C_HLD: begin
`endif
                    if (idx == LAST) begin
                        state    <= FIN;
                        done     <= 1'b1;
                        rId      <= '0;
                        rIn      <= '0;
                        memAddr  <= '0;
                        memWData <= '0;
                    end else begin
                        idx   <= idx + 1'b1;
                        rId   <= idx + 1'b1;
                        state <= S_RD;
                    end
                end
                R_RD: if (memAck) begin
                    memRe <= 1'b0;
                    rIn   <= memRData;
                    sp    <= sp - 1'b1;
                    rId   <= idx;
                    state <= R_SET;
                end
                R_SET: begin
                    ldR   <= 1'b1;
                    state <= R_LD;
                end
                R_LD: state <= R_HLD;
                R_HLD: begin
                    if (idx == '0) begin
                        state    <= FIN;
                        done     <= 1'b1;
                        rId      <= '0;
                        rIn      <= '0;
                        memAddr  <= '0;
                        memWData <= '0;
                    end else begin
                        idx     <= idx - 1'b1;
                        memRe   <= 1'b1;
                        memAddr <= sp - 1'b1;
                        state   <= R_RD;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_spill_fill.sv
// tb_reg_spill_fill: random save/restore traffic against a stack model of the spill area
module tb_reg_spill_fill;
    localparam int N = 8;
`ifdef REG_SPILL_CLEAR_EN
    localparam int SV = 5;
`else
    localparam int SV = 2;
`endif

    logic clk = 0, reset = 0, saveReq = 0, restoreReq = 0;
    logic busy, done, err, ldR, memWe, memRe, memAck;
    logic [7:0] sp, memAddr;
    logic [2:0] rId;
    logic [15:0] rIn, rOut, memWData, memRData;
    logic [15:0] mem [256];
    logic [15:0] bank [8];
    logic [15:0] exp_bank [8];
    logic [15:0] stk [$];
    logic [18:0] ldq [$];
    int wait_n = 0, wcnt = 0, viol = 0, checks = 0, errors = 0;
    logic pend = 0, pw = 0;
    logic [7:0] pa = 0;
    logic [15:0] pd = 0;

    logic b_save = 0, b_busy, b_done, b_err, b_ld, b_we, b_re;
    logic [2:0] b_sp, b_addr;
    logic [1:0] b_rid;
    logic [15:0] b_rin, b_wd;
    logic [15:0] b_mem [8];
    logic [15:0] b_bank [4];

    always #5 clk = ~clk;

    reg_spill_fill dut (
        .clk(clk), .reset(reset), .saveReq(saveReq), .restoreReq(restoreReq),
        .busy(busy), .done(done), .err(err), .sp(sp), .rId(rId), .ldR(ldR),
        .rIn(rIn), .rOut(rOut), .memAddr(memAddr), .memWData(memWData),
        .memWe(memWe), .memRe(memRe), .memRData(memRData), .memAck(memAck)
    );

    reg_spill_fill #(.NREGS(3), .ID_W(2), .ADDR_W(3)) dut2 (
        .clk(clk), .reset(reset), .saveReq(b_save), .restoreReq(1'b0),
        .busy(b_busy), .done(b_done), .err(b_err), .sp(b_sp), .rId(b_rid), .ldR(b_ld),
        .rIn(b_rin), .rOut(b_bank[b_rid]), .memAddr(b_addr), .memWData(b_wd),
        .memWe(b_we), .memRe(b_re), .memRData(b_mem[b_addr]), .memAck(b_we || b_re)
    );

    assign rOut     = bank[rId];
    assign memRData = mem[memAddr];
    assign memAck   = (memWe || memRe) && wcnt == wait_n;

    // memory with wait_n wait cycles, and the register bank written by ldR
    always @(posedge clk or negedge reset) begin
        if (!reset) wcnt <= 0;
        else begin
            wcnt <= ((memWe || memRe) && !memAck) ? wcnt + 1 : 0;
            if (memWe && memAck) mem[memAddr] = memWData;
            if (ldR) bank[rId] = rIn;
            if (b_we) b_mem[b_addr] = b_wd;
            if (b_ld) b_bank[b_rid] = b_rin;
        end
    end

    // load log plus bus invariants: no simultaneous we/re, request held stable until ack
    always @(negedge clk) begin
        if (ldR) ldq.push_back({rId, rIn});
        if (memWe && memRe) viol++;
        if (pend && (memWe !== pw || memRe === pw || memAddr !== pa || (pw && memWData !== pd))) viol++;
        pend = reset && (memWe || memRe) && !memAck;
        pw = memWe;
        pa = memAddr;
        pd = memWData;
    end

    always @(negedge reset) pend = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < N; i++) check(tag, bank[i], exp_bank[i]);
    endtask

    task automatic run_op(input logic s, input logic r, output int cyc);
        @(negedge clk);
        saveReq = s;
        restoreReq = r;
        @(posedge clk);
        @(negedge clk);
        saveReq = 0;
        restoreReq = 0;
        cyc = 1;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 2000) check("op_timeout", cyc, 0);
    endtask

    task automatic do_save(input int w, input logic r);
        int cyc, base;
        base = stk.size();
        wait_n = w;
        for (int i = 0; i < N; i++) begin
            stk.push_back(bank[i]);
            exp_bank[i] = (SV == 5) ? 16'h0 : bank[i];
        end
        run_op(1, r, cyc);
        check("save_lat", cyc, N * (SV + w) + 1);
        for (int i = 0; i < N; i++) check("save_mem", mem[base + i], stk[base + i]);
        check("save_sp", sp, stk.size());
        chk_bank("save_bank");
    endtask

    task automatic do_restore(input int w);
        int cyc;
        wait_n = w;
        ldq.delete();
        for (int i = N - 1; i >= 0; i--) exp_bank[i] = stk.pop_back();
        run_op(0, 1, cyc);
        check("rest_lat", cyc, N * (4 + w) + 1);
        check("rest_ldcnt", ldq.size(), N);
        for (int k = 0; k < N && k < ldq.size(); k++)
            check("rest_ld", ldq[k], {3'(N - 1 - k), exp_bank[N - 1 - k]});
        check("rest_sp", sp, stk.size());
        chk_bank("rest_bank");
    endtask

    task automatic rand_bank();
        for (int i = 0; i < N; i++) bank[i] = 16'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 0;
        for (int i = 0; i < 8; i++) begin
            bank[i] = 16'h1110 + 16'(i);
            b_mem[i] = 0;
        end
        for (int i = 0; i < 4; i++) b_bank[i] = 16'h0B00 + 16'(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_sp", sp, 0);
        check("rst_ldR", ldR, 0);
        check("rst_we_re", {memWe, memRe}, 0);
        @(negedge clk) reset = 1;
        do_save(0, 0);
        for (int i = 0; i < N; i++) begin
            mem[i] = 16'hA000 + 16'(i);
            stk[i] = 16'hA000 + 16'(i);
        end
        do_restore(0);
        @(negedge clk) restoreReq = 1;
        @(posedge clk);
        #1;
        check("err_restore", err, 1);
        check("err_busy", busy, 0);
        @(negedge clk) restoreReq = 0;
        @(posedge clk);
        #1;
        check("err_pulse_end", err, 0);
        check("err_sp", sp, 0);
        check("err_mem_idle", {memWe, memRe, ldR}, 0);
        rand_bank();
        do_save(3, 0);
        rand_bank();
        do_restore(3);
        repeat (10) begin
            int w;
            w = $urandom_range(0, 3);
            if (stk.size() >= N && $urandom_range(0, 1) == 1) do_restore(w);
            else if (stk.size() + N <= 240) begin
                rand_bank();
                do_save(w, 1'($urandom_range(0, 1)));
            end
        end
        while (stk.size() > N) do_restore(0);
        if (stk.size() == 0) begin
            rand_bank();
            do_save(0, 0);
        end
        rand_bank();
        do_save(0, 1);
        check("both_sp", sp, 16);
        @(negedge clk) restoreReq = 1;
        @(posedge clk);
        @(negedge clk) restoreReq = 0;
        repeat (5) @(posedge clk);
        #2 reset = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ldR", ldR, 0);
        check("midrst_sp", sp, 0);
        check("midrst_re", memRe, 0);
        stk.delete();
        @(negedge clk) reset = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) b_save = 1;
            @(posedge clk);
            #1;
            check("b_err", b_err, k == 2);
            check("b_busy", b_busy, k != 2);
            @(negedge clk) b_save = 0;
            repeat (20) @(posedge clk);
            #1;
            check("b_sp", b_sp, (k == 2) ? 6 : 3 * (k + 1));
            check("b_idle", {b_busy, b_we, b_ld}, 0);
        end
        for (int i = 0; i < 6; i++) check("b_mem", b_mem[i], 16'h0B00 + 16'(i % 3));
        check("bus_invariants", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
